// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
// Used by hazard_scoreboard and hazard_src_lookup.
package hazard_pkg;

   localparam int ST_E  = 0;
   localparam int ST_M  = 1;
   localparam int ST_M2 = 2;
   localparam int ST_W  = 3;

   localparam logic [1:0] RDY_ALU  = 2'd0;
   localparam logic [1:0] RDY_CP0  = 2'd1;
   localparam logic [1:0] RDY_LOAD = 2'd2;

   typedef enum logic [2:0] {
      FWD_RF = 3'b000,
      FWD_W  = 3'b001,
      FWD_M2 = 3'b010,
      FWD_M  = 3'b011,
      FWD_E  = 3'b100
   } fwd_sel_e;

   typedef struct packed {
      logic       valid;
      logic [1:0] age;
      logic [1:0] rdy;
   } sb_entry_t;

   function automatic fwd_sel_e stageFwd(input logic [1:0] age);
      fwd_sel_e sel;
      case (age)
         2'd0:    sel = FWD_E;
         2'd1:    sel = FWD_M;
         2'd2:    sel = FWD_M2;
         default: sel = FWD_W;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_src_lookup.sv
// Per-source scoreboard lookup: forwarding select and hazard bit for one
// source register against the registered table.
import hazard_pkg::*;

module hazard_src_lookup #(
   parameter int NREG = 32
) (
   input  sb_entry_t [NREG-1:0] sbTable,
   input  logic [4:0]           src,
   output logic [2:0]           fwd,
   output logic                 hazard
);

   sb_entry_t ent;
   logic      hit;

   always_comb begin
      ent    = sbTable[src];
      hit    = ent.valid && (src != 5'd0);
      fwd    = hit ? stageFwd(ent.age) : FWD_RF;
      // Result not yet forwardable while the producer is younger than its ready stage.
      hazard = hit && (ent.age < ent.rdy);
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Multi-lane register scoreboard: tracks in-flight producers per register,
// drives forwarding selects and lane issue grants. HAZARD_PERF_EN adds perf counters.
import hazard_pkg::*;

module hazard_scoreboard #(
   parameter int LANES  = 2,
   parameter int NREG   = 32,
   parameter int NSTAGE = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  freeze,
   input  logic                  flush,
   input  logic [LANES-1:0]      issue_valid,
   input  logic [LANES-1:0][4:0] rs,
   input  logic [LANES-1:0][4:0] rt,
   input  logic [LANES-1:0]      wen,
   input  logic [LANES-1:0][4:0] wdst,
   input  logic [LANES-1:0][1:0] rdy_stage,
   output logic [LANES-1:0]      issue_ok,
   output logic                  stall_d,
   output logic [LANES-1:0][2:0] fwd_rs,
   output logic [LANES-1:0][2:0] fwd_rt
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]           perf_stall_cyc,
   output logic [31:0]           perf_split_cyc
`endif
);

   localparam logic [1:0] AGE_LAST = 2'(NSTAGE - 1);

   sb_entry_t [NREG-1:0] sbTable;
   sb_entry_t [NREG-1:0] sbNext;
   logic [LANES-1:0]     hazRs;
   logic [LANES-1:0]     hazRt;
   logic [LANES-1:0]     laneHaz;
   logic [LANES-1:0]     intraDep;
   logic [LANES-1:0]     grant;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      hazard_src_lookup #(.NREG(NREG)) u_rs (
         .sbTable(sbTable), .src(rs[l]), .fwd(fwd_rs[l]), .hazard(hazRs[l])
      );
      hazard_src_lookup #(.NREG(NREG)) u_rt (
         .sbTable(sbTable), .src(rt[l]), .fwd(fwd_rt[l]), .hazard(hazRt[l])
      );
   end

   always_comb begin
      laneHaz  = hazRs | hazRt;
      intraDep = '0;
      for (int l = 1; l < LANES; l++) begin
         for (int k = 0; k < l; k++) begin
            if (wen[k] && (wdst[k] != 5'd0) && ((wdst[k] == rs[l]) || (wdst[k] == rt[l])))
               intraDep[l] = 1'b1;
         end
      end
      grant    = '0;
      grant[0] = issue_valid[0] & ~freeze & ~flush & ~laneHaz[0] & ~intraDep[0];
      // Lanes issue strictly in order; a blocked lane also holds every younger lane.
      for (int l = 1; l < LANES; l++)
         grant[l] = grant[l-1] & issue_valid[l] & ~laneHaz[l] & ~intraDep[l];
      issue_ok = grant & {LANES{resetn}};
      stall_d  = issue_valid[0] & laneHaz[0];
   end

   always_comb begin
      sbNext = sbTable;
      for (int r = 1; r < NREG; r++) begin
         if (sbTable[r].valid) begin
            if (flush && (sbTable[r].age <= 2'(ST_M)))
               sbNext[r].valid = 1'b0;
            else if (!freeze) begin
               if (sbTable[r].age == AGE_LAST)
                  sbNext[r].valid = 1'b0;
               else
                  sbNext[r].age = sbTable[r].age + 2'd1;
            end
         end
      end
      // Later lanes are younger, so their write to a shared register must win.
      for (int l = 0; l < LANES; l++) begin
         if (grant[l] && wen[l] && (wdst[l] != 5'd0)) begin
            sbNext[wdst[l]].valid = 1'b1;
            sbNext[wdst[l]].age   = 2'(ST_E);
            sbNext[wdst[l]].rdy   = rdy_stage[l];
         end
      end
      sbNext[0] = '0;
   end

   always_ff @(posedge clk) begin
      if (!resetn)
         sbTable <= '0;
      else
         sbTable <= sbNext;
   end

`ifdef HAZARD_PERF_EN
   logic splitEvt;

   always_comb begin
      splitEvt = 1'b0;
      for (int l = 1; l < LANES; l++) begin
         if (l == 1)
            splitEvt = grant[0] & issue_valid[l] & ~laneHaz[l] & intraDep[l];
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         perf_stall_cyc <= '0;
         perf_split_cyc <= '0;
      end else begin
         if (stall_d)
            perf_stall_cyc <= perf_stall_cyc + 32'd1;
         if (splitEvt)
            perf_split_cyc <= perf_split_cyc + 32'd1;
      end
   end
`endif

endmodule
